// File: rtl/ascon_pkg.sv
// ascon_pkg: shared round counts, scheduler state encoding and round-constant helper.
package ascon_pkg;

    localparam int ASCON_ROUNDS_A = 12;
    localparam int ASCON_ROUNDS_B = 6;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

    typedef logic [3:0] rnd_idx_t;

    function automatic logic [7:0] rc(input rnd_idx_t i);
        return {~i, i};
    endfunction

endpackage

// File: rtl/ascon_rr_arb2.sv
// ascon_rr_arb2: two-way round-robin arbiter; on a tie the requester that did not own last wins.
module ascon_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] win
);

    always_comb win = (req == 2'b11) ? (last_owner ? 2'b01 : 2'b10) : req;

endmodule

// File: rtl/ascon_perm_scheduler.sv
// ascon_perm_scheduler: shares one Ascon round datapath between two requesters and
// sequences load, per-cycle round constants and completion for each permutation.
module ascon_perm_scheduler
    import ascon_pkg::*;
#(
    parameter int UNROLL   = 1,
    parameter int ROUNDS_A = ASCON_ROUNDS_A,
    parameter int ROUNDS_B = ASCON_ROUNDS_B
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [1:0]          req_pb,
    input  logic                flush,
    output logic [1:0]          gnt,
    output logic [1:0]          done,
    output logic                owner,
    output logic                busy,
    output logic                load_en,
    output logic                rnd_valid,
    output logic [8*UNROLL-1:0] rnd_const,
    output logic                rnd_last
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 3 && UNROLL != 6) begin : g_bad_unroll
        $error("ascon_perm_scheduler: UNROLL must be 1, 2, 3 or 6");
    end

    localparam rnd_idx_t STEP    = rnd_idx_t'(UNROLL);
    localparam rnd_idx_t LAST    = rnd_idx_t'(ROUNDS_A);
    localparam rnd_idx_t START_B = rnd_idx_t'(ROUNDS_A - ROUNDS_B);

    state_t   state, state_d;
    logic     owner_q, pb, last_owner;
    logic     [1:0] win;
    rnd_idx_t cnt, cnt_nxt;

    ascon_rr_arb2 u_arb (
        .req        (req),
        .last_owner (last_owner),
        .win        (win)
    );

    assign cnt_nxt = cnt + STEP;

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: state_d = (|win) ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  state_d = (cnt_nxt == LAST) ? ST_DONE : ST_RUN;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner_q    <= 1'b0;
            pb         <= 1'b0;
            cnt        <= '0;
            last_owner <= 1'b1;
        end else begin
            state <= state_d;
            if (state == ST_IDLE && state_d == ST_LOAD) begin
                owner_q <= win[1];
                pb      <= req_pb[win[1]];
            end
            // p^b runs the tail of the p^a schedule, so it starts mid-table
            if (state == ST_LOAD) cnt <= pb ? START_B : '0;
            else if (state == ST_RUN) cnt <= cnt_nxt;
            if (state == ST_DONE && !flush) last_owner <= owner_q;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign load_en   = (state == ST_LOAD);
    assign rnd_valid = (state == ST_RUN);
    assign rnd_last  = rnd_valid && (cnt_nxt == LAST);
    assign owner     = owner_q;
    assign gnt       = load_en ? {owner_q, ~owner_q} : 2'b00;
    assign done      = (state == ST_DONE && !flush) ? {owner_q, ~owner_q} : 2'b00;

    for (genvar k = 0; k < UNROLL; k++) begin : g_lane
        assign rnd_const[8*k +: 8] = rnd_valid ? rc(cnt + rnd_idx_t'(k)) : 8'h00;
    end

endmodule
